// File: rtl/fifo_drain_ctrl_if.sv
// Read-port and output-stream signal bundle for fifo_drain_ctrl.
// master is the drain controller; slave is the FIFO plus the stream consumer.
interface fifo_drain_ctrl_if #(
  parameter int unsigned WIDTH = 128
);

  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_data;
  logic             fifo_rd;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;

  modport master (
    input  fifo_empty,
    input  fifo_data,
    input  m_ready,
    output fifo_rd,
    output m_valid,
    output m_data
  );

  modport slave (
    output fifo_empty,
    output fifo_data,
    output m_ready,
    input  fifo_rd,
    input  m_valid,
    input  m_data
  );

endinterface

// File: rtl/fifo_drain_ctrl.sv
// Read-side controller for a one-cycle-latency synchronous FIFO: issues reads under a
// credit rule and presents captured words on a valid/ready stream via a 3-entry buffer.
module fifo_drain_ctrl #(
  parameter int unsigned WIDTH = 128,
  parameter int unsigned CNT_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  fifo_drain_ctrl_if.master bus,
  output logic              busy,
  output logic [CNT_W-1:0]  beat_count
);

  localparam int unsigned DEPTH = 3;
  localparam int unsigned PTR_W = 2;
  localparam int unsigned CRD_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } state_e;

  state_e           state_q;
  state_e           state_d;
  logic [PTR_W-1:0] count_q;
  logic [PTR_W-1:0] count_d;
  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] head_d;
  logic [PTR_W-1:0] tail_q;
  logic [PTR_W-1:0] tail_d;
  logic             inflight_q;
  logic [WIDTH-1:0] buf_q [DEPTH];
  logic [CNT_W-1:0] beat_q;

  logic             credit_ok_c;
  logic             rd_c;
  logic             valid_c;
  logic             push_c;
  logic             pop_c;
  logic [WIDTH-1:0] head_data_c;

  // Circular pointer advance over three slots.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Buffered plus in-flight words must leave room for the word a new read returns.
  assign credit_ok_c = (CRD_W'(count_q) + CRD_W'(inflight_q)) < CRD_W'(DEPTH);
  assign rd_c        = (state_q == ST_RUN) && !bus.fifo_empty && credit_ok_c;
  assign valid_c     = (count_q != '0);
  assign push_c      = inflight_q;
  assign pop_c       = valid_c && bus.m_ready;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; STOP lingers until nothing is buffered or in flight.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (en) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!en) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (en) begin
          state_d = ST_RUN;
        end else if (!inflight_q && (count_q == '0)) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Occupancy and pointer updates; simultaneous capture and pop leave count unchanged.
  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (push_c) tail_d = ptr_inc(tail_q);
    if (pop_c)  head_d = ptr_inc(head_q);
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + PTR_W'(1);
      2'b01:   count_d = count_q - PTR_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      inflight_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      inflight_q <= rd_c;
    end
  end

  // Capture the returned FIFO word into the tail slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        buf_q[i] <= '0;
      end
    end else if (push_c) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (tail_q == PTR_W'(i)) buf_q[i] <= bus.fifo_data;
      end
    end
  end

  always_comb begin
    head_data_c = '0;
    case (head_q)
      2'd0:    head_data_c = buf_q[0];
      2'd1:    head_data_c = buf_q[1];
      2'd2:    head_data_c = buf_q[2];
      default: head_data_c = '0;
    endcase
  end

  // Delivered-beat counter, wraps naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      beat_q <= '0;
    end else if (pop_c) begin
      beat_q <= beat_q + CNT_W'(1);
    end
  end

  assign bus.fifo_rd = rd_c;
  assign bus.m_valid = valid_c;
  assign bus.m_data  = head_data_c;
  assign busy        = (state_q != ST_IDLE);
  assign beat_count  = beat_q;

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Scoreboard bench for fifo_drain_ctrl: a FIFO model feeds the DUT, a monitor checks
// every cycle against a credit/occupancy reference and an in-order expected-word queue.
module tb_fifo_drain_ctrl;

  localparam int unsigned WIDTH = 128;
  localparam int unsigned CNT_W = 32;
  typedef logic [WIDTH-1:0] word_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             en;
  logic             busy;
  logic [CNT_W-1:0] beat_count;

  fifo_drain_ctrl_if #(.WIDTH(WIDTH)) bus ();

  fifo_drain_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .bus        (bus),
    .busy       (busy),
    .beat_count (beat_count)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_chk  = 0;

  word_t fifo_q[$];   // words still inside the FIFO
  word_t exp_q[$];    // every pushed word not yet delivered, in order

  // reference model state (values after the most recent edge)
  int               m_out     = 0;   // words read but not delivered
  bit               m_rd_prev = 1'b0;
  bit               m_en_prev = 1'b0;
  bit               m_busy    = 1'b0;
  logic [CNT_W-1:0] exp_beats = '0;
  int               obs_out   = 0;
  int               rd_total  = 0;
  int               hs_total  = 0;
  int               hs_streak = 0;
  bit               hs_prev   = 1'b0;

  task automatic chk(input string name, input word_t act, input word_t exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: compares DUT outputs against the reference every falling edge.
  always @(negedge clk) begin : monitor
    bit rd_o, hs_o, rd_e, valid_e, hs_e;
    if (reset !== 1'b1) begin
      chk("rst_fifo_rd", word_t'(bus.fifo_rd), '0);
      chk("rst_m_valid", word_t'(bus.m_valid), '0);
      chk("rst_m_data", bus.m_data, '0);
      chk("rst_busy", word_t'(busy), '0);
      chk("rst_beat_count", word_t'(beat_count), '0);
      m_out = 0; m_rd_prev = 1'b0; m_en_prev = 1'b0; m_busy = 1'b0;
      exp_beats = '0; obs_out = 0; hs_prev = 1'b0;
    end else begin
      rd_o    = bus.fifo_rd;
      hs_o    = bus.m_valid && bus.m_ready;
      rd_e    = m_en_prev && !bus.fifo_empty && (m_out < 3);
      valid_e = (m_out - int'(m_rd_prev)) > 0;
      hs_e    = valid_e && bus.m_ready;
      chk("fifo_rd", word_t'(rd_o), word_t'(rd_e));
      chk("m_valid", word_t'(bus.m_valid), word_t'(valid_e));
      chk("busy", word_t'(busy), word_t'(m_busy));
      chk("beat_count", word_t'(beat_count), word_t'(exp_beats));
      if (valid_e) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL m_data_sb: valid with no expected word at %0t", $time);
        end else begin
          chk("m_data", bus.m_data, exp_q[0]);
        end
      end
      obs_out = obs_out + int'(rd_o) - int'(hs_o);
      chk("occupancy_le3", word_t'(obs_out <= 3), word_t'(1));
      if (hs_e && exp_q.size() != 0) void'(exp_q.pop_front());
      if (hs_e) exp_beats = exp_beats + CNT_W'(1);
      m_busy    = en || m_en_prev || (m_busy && (m_out != 0));
      m_out     = m_out + int'(rd_e) - int'(hs_e);
      m_rd_prev = rd_e;
      m_en_prev = en;
      rd_total  = rd_total + int'(rd_o);
      hs_total  = hs_total + int'(hs_o);
      if (hs_o) hs_streak = hs_prev ? hs_streak + 1 : 1;
      hs_prev = hs_o;
    end
  end

  task automatic push_word(input word_t w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
    bus.fifo_empty = 1'b0;
  endtask

  // One clock: FIFO returns read data after the edge, then new inputs are applied.
  task automatic tick(input bit rdy, input bit e);
    bit rd_s;
    @(negedge clk);
    rd_s = bus.fifo_rd;
    @(posedge clk);
    #1;
    if (rd_s && reset && fifo_q.size() != 0) bus.fifo_data = fifo_q.pop_front();
    bus.m_ready    = rdy;
    en             = e;
    bus.fifo_empty = (fifo_q.size() == 0);
  endtask

  // Asynchronous reset mid-cycle; FIFO is reset alongside.
  task automatic do_reset();
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_m_valid", word_t'(bus.m_valid), '0);
    chk("async_rst_fifo_rd", word_t'(bus.fifo_rd), '0);
    chk("async_rst_busy", word_t'(busy), '0);
    fifo_q.delete();
    exp_q.delete();
    bus.fifo_data  = '0;
    bus.fifo_empty = 1'b1;
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    reset = 1'b1;
  endtask

  initial begin : stimulus
    int rd0, hs0, guard;
    bit en_v, rdy_v;
    reset = 1'b1;
    en = 1'b1;
    bus.m_ready = 1'b0;
    bus.fifo_empty = 1'b1;
    bus.fifo_data = '0;
    #1 reset = 1'b0;

    // reset held with en=1 and a non-empty FIFO, then release
    for (int i = 1; i <= 4; i++) push_word(word_t'(32'hA0 + i));
    repeat (3) tick(1'b0, 1'b1);
    reset = 1'b1;
    tick(1'b1, 1'b1);
    chk("rst_first_rd", word_t'(bus.fifo_rd), word_t'(1));
    repeat (8) tick(1'b1, 1'b1);

    // streaming 1..8 at full rate
    do_reset();
    rd0 = rd_total; hs0 = hs_total;
    for (int i = 1; i <= 8; i++) push_word(word_t'(i));
    repeat (15) tick(1'b1, 1'b1);
    chk("stream_rd_count", word_t'(rd_total - rd0), word_t'(8));
    chk("stream_hs_count", word_t'(hs_total - hs0), word_t'(8));
    chk("stream_consecutive", word_t'(hs_streak), word_t'(8));
    chk("stream_beat_count", word_t'(beat_count), word_t'(8));
    chk("stream_valid_low", word_t'(bus.m_valid), '0);

    // back-pressure: six words, consumer stalled
    do_reset();
    rd0 = rd_total; hs0 = hs_total;
    for (int i = 1; i <= 6; i++) push_word(word_t'(32'h100 + i));
    repeat (11) tick(1'b0, 1'b1);
    chk("bp_rd_count", word_t'(rd_total - rd0), word_t'(3));
    chk("bp_hs_count", word_t'(hs_total - hs0), '0);
    chk("bp_valid", word_t'(bus.m_valid), word_t'(1));
    chk("bp_head_word", bus.m_data, word_t'(32'h101));
    repeat (12) tick(1'b1, 1'b1);
    chk("bp_hs_after", word_t'(hs_total - hs0), word_t'(6));
    chk("bp_no_gaps", word_t'(hs_streak), word_t'(6));
    chk("bp_beat_count", word_t'(beat_count), word_t'(6));

    // graceful stop: en drops in the cycle the first read is issued
    do_reset();
    rd0 = rd_total; hs0 = hs_total;
    for (int i = 1; i <= 5; i++) push_word(word_t'(32'h200 + i));
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b0);
    repeat (8) tick(1'b1, 1'b0);
    chk("stop_rd_count", word_t'(rd_total - rd0), word_t'(1));
    chk("stop_hs_count", word_t'(hs_total - hs0), word_t'(1));
    chk("stop_busy_low", word_t'(busy), '0);
    chk("stop_valid_low", word_t'(bus.m_valid), '0);

    // mid-burst asynchronous reset
    do_reset();
    for (int i = 1; i <= 4; i++) push_word(word_t'(32'h300 + i));
    repeat (6) tick(1'b0, 1'b1);
    chk("pre_rst_valid", word_t'(bus.m_valid), word_t'(1));
    do_reset();

    // beat counter wrap
    push_word(word_t'(32'h401));
    push_word(word_t'(32'h402));
    repeat (4) tick(1'b0, 1'b1);
    #1 force dut.beat_q = 32'hFFFF_FFFF;
    #1 release dut.beat_q;
    exp_beats = 32'hFFFF_FFFF;
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);
    chk("beat_wrap", word_t'(beat_count), '0);
    repeat (4) tick(1'b1, 1'b1);

    // random stress
    do_reset();
    en_v = 1'b1;
    for (int c = 0; c < 800; c++) begin
      if (fifo_q.size() < 12 && $urandom_range(0, 99) < 55)
        push_word({$urandom(), $urandom(), $urandom(), $urandom()});
      if (fifo_q.size() < 12 && $urandom_range(0, 99) < 15)
        push_word({$urandom(), $urandom(), $urandom(), $urandom()});
      rdy_v = ($urandom_range(0, 99) < 60);
      if ($urandom_range(0, 99) < 6) en_v = !en_v;
      tick(rdy_v, en_v);
    end
    guard = 0;
    while ((exp_q.size() != 0 || busy) && guard < 300) begin
      tick(1'b1, exp_q.size() != 0);
      guard++;
    end
    chk("stress_drained", word_t'(exp_q.size() == 0 && !busy), word_t'(1));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
